// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its producers / register file.
// WB_PERF_EN adds the two performance counter outputs.
interface wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  a_valid;
  logic                  a_ready;
  logic [4:0]            a_rd;
  logic [DATA_WIDTH-1:0] a_val;
  logic                  a_f;
  logic                  b_valid;
  logic                  b_ready;
  logic [4:0]            b_rd;
  logic [DATA_WIDTH-1:0] b_val;
  logic                  b_f;
  logic                  regWrite;
  logic [4:0]            rd;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  f_en;
  logic [CW-1:0]         fifo_count;
`ifdef WB_PERF_EN
  logic [15:0]           perf_force_cnt;
  logic [15:0]           perf_bfull_cnt;
`endif

  modport slave (
    input  a_valid, a_rd, a_val, a_f, b_valid, b_rd, b_val, b_f,
    output a_ready, b_ready, regWrite, rd, rd_val, f_en, fifo_count
`ifdef WB_PERF_EN
    , output perf_force_cnt, perf_bfull_cnt
`endif
  );

  modport master (
    output a_valid, a_rd, a_val, a_f, b_valid, b_rd, b_val, b_f,
    input  a_ready, b_ready, regWrite, rd, rd_val, f_en, fifo_count
`ifdef WB_PERF_EN
    , input perf_force_cnt, perf_bfull_cnt
`endif
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results (A) vs. FIFO-buffered long-latency results (B),
// with an anti-starvation forced drain. WB_PERF_EN adds saturating perf counters.
module wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            mem_rd_r  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_val_r [FIFO_DEPTH];
  logic                  mem_f_r   [FIFO_DEPTH];
  logic [PW-1:0]         wptr_r, rptr_r;
  logic [CW-1:0]         count_r;
  logic [AW-1:0]         age_r;

  logic                  empty_s, force_s, push_s, pop_s, sel_s, wr_s;
  logic [4:0]            sel_rd_s;
  logic [DATA_WIDTH-1:0] sel_val_s;
  logic                  sel_f_s;

  // Handshakes and source selection; force only ever holds while the FIFO is non-empty.
  always_comb begin
    empty_s    = (count_r == CW'(0));
    force_s    = (age_r == AW'(STARVE_LIMIT));
    wb.b_ready = !rst && (count_r < CW'(FIFO_DEPTH));
    wb.a_ready = !rst && !force_s;
    push_s     = wb.b_valid && wb.b_ready;
    pop_s      = 1'b0;
    sel_s      = 1'b0;
    sel_rd_s   = 5'd0;
    sel_val_s  = {DATA_WIDTH{1'b0}};
    sel_f_s    = 1'b0;
    if (force_s || (!wb.a_valid && !empty_s)) begin
      pop_s     = 1'b1;
      sel_s     = 1'b1;
      sel_rd_s  = mem_rd_r[rptr_r];
      sel_val_s = mem_val_r[rptr_r];
      sel_f_s   = mem_f_r[rptr_r];
    end else if (wb.a_valid) begin
      sel_s     = 1'b1;
      sel_rd_s  = wb.a_rd;
      sel_val_s = wb.a_val;
      sel_f_s   = wb.a_f;
    end else begin
      sel_s     = 1'b0;
    end
    // integer x0 is hardwired zero, so such a write collapses to idle output
    wr_s = sel_s && ((sel_rd_s != 5'd0) || sel_f_s);
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_rd_r[wptr_r]  <= wb.b_rd;
      mem_val_r[wptr_r] <= wb.b_val;
      mem_f_r[wptr_r]   <= wb.b_f;
    end
  end

  // Pointers, occupancy, head age and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r      <= PW'(0);
      rptr_r      <= PW'(0);
      count_r     <= CW'(0);
      age_r       <= AW'(0);
      wb.regWrite <= 1'b0;
      wb.rd       <= 5'd0;
      wb.rd_val   <= {DATA_WIDTH{1'b0}};
      wb.f_en     <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + PW'(1);
      if (pop_s)  rptr_r <= rptr_r + PW'(1);
      count_r     <= count_r + CW'(push_s) - CW'(pop_s);
      age_r       <= (empty_s || pop_s) ? AW'(0) : age_r + AW'(1);
      wb.regWrite <= wr_s;
      wb.rd       <= wr_s ? sel_rd_s : 5'd0;
      wb.rd_val   <= wr_s ? sel_val_s : {DATA_WIDTH{1'b0}};
      wb.f_en     <= wr_s ? sel_f_s : 1'b0;
    end
  end

  assign wb.fifo_count = count_r;

`ifdef WB_PERF_EN
  logic [15:0] force_cnt_r, bfull_cnt_r;

  // Saturating counters of forced drains and B back-pressure cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      force_cnt_r <= 16'd0;
      bfull_cnt_r <= 16'd0;
    end else begin
      if (force_s && (force_cnt_r != 16'hFFFF)) force_cnt_r <= force_cnt_r + 16'd1;
      if (wb.b_valid && !wb.b_ready && (bfull_cnt_r != 16'hFFFF)) bfull_cnt_r <= bfull_cnt_r + 16'd1;
    end
  end

  assign wb.perf_force_cnt = force_cnt_r;
  assign wb.perf_bfull_cnt = bfull_cnt_r;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus randomized bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] val;
    logic          f;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  wb_arbiter_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) wb ();

  wb_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  int   age      = 0;
  int   m_force  = 0;
  int   m_bfull  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the current inputs, advance, compare registered outputs.
  task automatic tick();
    ent_t e;
    bit   sel, forced, popped;
    int   sz;
    e.rd = 5'd0; e.val = '0; e.f = 1'b0;
    sel = 0;
    #1;
    if (rst) begin
      chk("a_ready_rst", {63'd0, wb.a_ready}, 64'd0);
      chk("b_ready_rst", {63'd0, wb.b_ready}, 64'd0);
      q.delete();
      age = 0; m_force = 0; m_bfull = 0;
    end else begin
      sz     = q.size();
      forced = (sz > 0) && (age == STARVE);
      popped = 0;
      chk("a_ready", {63'd0, wb.a_ready}, {63'd0, !forced});
      chk("b_ready", {63'd0, wb.b_ready}, {63'd0, sz < DEPTH});
      if (forced || (!wb.a_valid && sz > 0)) begin
        e = q.pop_front(); sel = 1; popped = 1;
      end else if (wb.a_valid) begin
        e.rd = wb.a_rd; e.val = wb.a_val; e.f = wb.a_f; sel = 1;
      end
      if (wb.b_valid && sz < DEPTH) q.push_back('{wb.b_rd, wb.b_val, wb.b_f});
      if (wb.b_valid && sz >= DEPTH) m_bfull++;
      if (forced) m_force++;
      age = (sz > 0 && !popped) ? age + 1 : 0;
      if (!(sel && (e.rd != 5'd0 || e.f))) begin
        sel = 0; e.rd = 5'd0; e.val = '0; e.f = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("regWrite",   {63'd0, wb.regWrite}, {63'd0, sel});
    chk("rd",         {59'd0, wb.rd}, {59'd0, e.rd});
    chk("rd_val",     {32'd0, wb.rd_val}, {32'd0, e.val});
    chk("f_en",       {63'd0, wb.f_en}, {63'd0, e.f});
    chk("fifo_count", 64'(wb.fifo_count), 64'(q.size()));
`ifdef WB_PERF_EN
    chk("perf_force", {48'd0, wb.perf_force_cnt}, 64'(m_force));
    chk("perf_bfull", {48'd0, wb.perf_bfull_cnt}, 64'(m_bfull));
`endif
  endtask

  task automatic drive_a(input logic v, input logic [4:0] r, input logic [DW-1:0] d, input logic f);
    wb.a_valid = v; wb.a_rd = r; wb.a_val = d; wb.a_f = f;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] r, input logic [DW-1:0] d, input logic f);
    wb.b_valid = v; wb.b_rd = r; wb.b_val = d; wb.b_f = f;
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 5'd0, 32'd0, 1'b0);
    drive_b(1'b0, 5'd0, 32'd0, 1'b0);
    // reset for two cycles, then release
    tick(); tick();
    rst = 1'b0;
    tick();
    // single ALU write, then idle
    drive_a(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    tick();
    drive_a(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    // A and B together with an empty FIFO: A first, B one cycle later
    drive_a(1'b1, 5'd3, 32'h1, 1'b0);
    drive_b(1'b1, 5'd9, 32'h2, 1'b1);
    tick();
    drive_a(1'b0, 5'd0, 32'd0, 1'b0);
    drive_b(1'b0, 5'd0, 32'd0, 1'b0);
    tick(); tick();
    // A held high while four B results fill the FIFO; forced drains in order
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 5'd20, 32'($urandom), 1'b0);
      drive_b(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0);
      tick();
    end
    drive_b(1'b1, 5'd14, 32'h200, 1'b0);
    tick();
    chk("fifo_full_count", 64'(wb.fifo_count), 64'd4);
    drive_b(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive_a(1'b1, 5'(i % 31 + 1), 32'($urandom), 1'b0);
      tick();
    end
    // three entries buffered, then a mid-operation reset discards them
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 5'(16 + i), 32'h300 + 32'(i), 1'b1);
      tick();
    end
    drive_b(1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_a(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_count", 64'(wb.fifo_count), 64'd0);
    // write to x0 is suppressed
    drive_a(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    drive_a(1'b1, 5'd0, 32'h1234_5678, 1'b1);
    tick();
    drive_a(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    // randomized traffic: light A load, then heavy A load to provoke starvation
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 300; i++) begin
        rst = ($urandom_range(0, 199) == 0);
        drive_a($urandom_range(0, 99) < (p == 0 ? 40 : 95),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                32'($urandom), 1'($urandom));
        drive_b($urandom_range(0, 99) < 55,
                ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                32'($urandom), 1'($urandom));
        tick();
      end
    end
    rst = 1'b0;
    drive_a(1'b0, 5'd0, 32'd0, 1'b0);
    drive_b(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
